// File: rtl/wbn_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port. Ownership lasts a whole
// cyc assertion. Grant decisions are registered, and the owner's requests pass through combinationally.
module wbn_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int N  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_cyc,
  input  logic [N-1:0]    m_we,
  input  logic [N-1:0]    m_stb,
  input  logic [N*AW-1:0] m_adr,
  input  logic [N*SW-1:0] m_sel,
  input  logic [N*DW-1:0] m_dat_w,
  output logic [DW-1:0]   m_dat_r,
  output logic [N-1:0]    m_ack,
  output logic [N-1:0]    m_err,
  output logic [N-1:0]    m_rty,
  output logic            s_cyc,
  output logic            s_we,
  output logic            s_stb,
  output logic [AW-1:0]   s_adr,
  output logic [SW-1:0]   s_sel,
  output logic [DW-1:0]   s_dat_w,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic            s_rty,
  output logic [N-1:0]    gnt
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] pick, idx;
  logic          found;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && m_cyc[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          state_d     = BUSY;
          owner_d     = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        if (!m_cyc[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so each one samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // The slave side sees only the owner. Outside BUSY, every slave request output reads zero.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    if (state_q == BUSY) begin
      s_cyc   = m_cyc[owner_q];
      s_stb   = m_stb[owner_q];
      s_we    = m_we[owner_q];
      s_adr   = m_adr[int'(owner_q) * AW +: AW];
      s_sel   = m_sel[int'(owner_q) * SW +: SW];
      s_dat_w = m_dat_w[int'(owner_q) * DW +: DW];
    end
  end

  // gnt_q is one-hot on the owner, so masking with it routes termination to the owner alone.
  assign m_ack   = {N{s_ack}} & gnt_q;
  assign m_err   = {N{s_err}} & gnt_q;
  assign m_rty   = {N{s_rty}} & gnt_q;
  assign m_dat_r = s_dat_r;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_wbn_arbiter.sv
// Bench for wbn_arbiter with N=4. It runs directed scenarios and then a random
// phase, and checks against a reference model that tracks only the owner and pointer.
module tb_wbn_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_we, m_stb;
  logic [N*AW-1:0] m_adr;
  logic [N*SW-1:0] m_sel;
  logic [N*DW-1:0] m_dat_w;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic            s_cyc, s_we, s_stb;
  logic [AW-1:0]   s_adr;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_dat_w, s_dat_r;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    gnt;

  int mdl_owner;  // -1 when idle
  int mdl_ptr;
  int n_checks = 0;
  int n_fail   = 0;

  wbn_arbiter #(.AW(AW), .DW(DW), .SW(SW), .N(N)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_we(m_we), .m_stb(m_stb), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_cyc(s_cyc), .s_we(s_we), .s_stb(s_stb), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected outputs follow from the model: nothing before a grant, then the owner's mirror.
  task automatic compare_outputs(input string ctx);
    logic [N-1:0]  e_gnt, e_ack, e_err, e_rty;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [SW-1:0] e_sel;
    logic [DW-1:0] e_dat;
    logic [1:0]    o;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_sel = '0; e_dat = '0;
    if (mdl_owner >= 0) begin
      o        = 2'(mdl_owner);
      e_gnt[o] = 1'b1;
      e_cyc    = m_cyc[o];
      e_stb    = m_stb[o];
      e_we     = m_we[o];
      e_adr    = m_adr[o * AW +: AW];
      e_sel    = m_sel[o * SW +: SW];
      e_dat    = m_dat_w[o * DW +: DW];
      if (s_ack) e_ack = e_gnt;
      if (s_err) e_err = e_gnt;
      if (s_rty) e_rty = e_gnt;
    end
    check({ctx, ":gnt"},     64'(gnt),     64'(e_gnt));
    check({ctx, ":s_cyc"},   64'(s_cyc),   64'(e_cyc));
    check({ctx, ":s_stb"},   64'(s_stb),   64'(e_stb));
    check({ctx, ":s_we"},    64'(s_we),    64'(e_we));
    check({ctx, ":s_adr"},   64'(s_adr),   64'(e_adr));
    check({ctx, ":s_sel"},   64'(s_sel),   64'(e_sel));
    check({ctx, ":s_dat_w"}, 64'(s_dat_w), 64'(e_dat));
    check({ctx, ":m_ack"},   64'(m_ack),   64'(e_ack));
    check({ctx, ":m_err"},   64'(m_err),   64'(e_err));
    check({ctx, ":m_rty"},   64'(m_rty),   64'(e_rty));
    check({ctx, ":m_dat_r"}, 64'(m_dat_r), 64'(s_dat_r));
  endtask

  // A clock edge in the model: grant the first requester from the pointer, or release on cyc drop.
  task automatic model_edge();
    bit found = 1'b0;
    if (mdl_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int j = (mdl_ptr + i) % N;
        if (!found && m_cyc[2'(j)]) begin
          mdl_owner = j;
          found     = 1'b1;
        end
      end
    end else if (!m_cyc[2'(mdl_owner)]) begin
      mdl_ptr   = (mdl_owner + 1) % N;
      mdl_owner = -1;
    end
  endtask

  // Callers drive inputs at a negedge. This checks them, steps one clock, and returns at the next negedge.
  task automatic cycle(input string ctx);
    #1;
    compare_outputs(ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_we = '0; m_stb = '0; m_adr = '0; m_sel = '0; m_dat_w = '0;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic set_master(input int i, input logic we, input logic [AW-1:0] adr,
                            input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    m_cyc[2'(i)]         = 1'b1;
    m_stb[2'(i)]         = 1'b1;
    m_we[2'(i)]          = we;
    m_adr[i * AW +: AW]   = adr;
    m_sel[i * SW +: SW]   = sel;
    m_dat_w[i * DW +: DW] = dat;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    mdl_owner = -1;
    mdl_ptr   = 0;
    @(negedge clk);
    #1 compare_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int          order[$];
    int          gap, hold;
    logic [N-1:0] prev;

    // Single master: master 1 writes 0xDEADBEEF to 0x10
    do_reset();
    set_master(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    cycle("single_req");
    check("single_gnt", 64'(gnt), 64'(4'b0010));
    s_ack = 1'b1;
    #1;
    check("single_adr", 64'(s_adr), 64'h10);
    check("single_dat", 64'(s_dat_w), 64'hDEADBEEF);
    check("single_ack", 64'(m_ack), 64'(4'b0010));
    cycle("single_ack");
    s_ack = 1'b0;
    m_cyc = '0;
    cycle("single_rel");

    // Contention from reset, then a repeated simultaneous request after the pointer has moved
    do_reset();
    set_master(0, 1'b0, 32'h0, 4'hF, '0);
    set_master(1, 1'b0, 32'h4, 4'hF, '0);
    cycle("cont_req");
    check("cont_first", 64'(gnt), 64'(4'b0001));
    m_cyc[0] = 1'b0;
    cycle("cont_rel0");
    check("cont_dead", 64'(gnt), 64'(4'b0000));
    cycle("cont_dead");
    check("cont_second", 64'(gnt), 64'(4'b0010));
    m_cyc = '0;
    cycle("cont_rel1");
    m_cyc = 4'b0011;
    cycle("cont_again");
    check("cont_wrap", 64'(gnt), 64'(4'b0001));
    m_cyc = '0;
    cycle("cont_end");

    // Locked cycle: master 0 performs three reads while master 1 waits
    do_reset();
    set_master(0, 1'b0, 32'h0, 4'hF, '0);
    set_master(1, 1'b1, 32'h40, 4'h3, 32'hCAFE0001);
    cycle("lock_req");
    for (int k = 0; k < 3; k++) begin
      m_adr[0 +: AW] = 32'(4 * k);
      s_ack          = 1'b1;
      s_dat_r        = $urandom;
      #1;
      check($sformatf("lock_gnt%0d", k), 64'(gnt), 64'(4'b0001));
      check($sformatf("lock_ack%0d", k), 64'(m_ack), 64'(4'b0001));
      cycle("lock_xfer");
    end
    s_ack    = 1'b0;
    m_cyc[0] = 1'b0;
    cycle("lock_rel");
    check("lock_idle", 64'(gnt), 64'(4'b0000));
    cycle("lock_next");
    check("lock_m1", 64'(gnt), 64'(4'b0010));

    // Error routing on a master 1 read
    do_reset();
    set_master(1, 1'b0, 32'h20, 4'hF, '0);
    cycle("err_req");
    s_err   = 1'b1;
    s_dat_r = 32'h12345678;
    #1;
    check("err_m_err", 64'(m_err), 64'(4'b0010));
    check("err_m_ack", 64'(m_ack), 64'(4'b0000));
    check("err_dat_r", 64'(m_dat_r), 64'h12345678);
    cycle("err_xfer");
    clear_inputs();
    cycle("err_end");

    // All masters requesting: each owner does one transfer, then drops cyc for a single cycle
    do_reset();
    gap  = 0;
    hold = 0;
    prev = '0;
    s_ack = 1'b1;
    m_stb = '1;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      if (gnt != '0 && prev == '0) begin
        for (int i = 0; i < N; i++) if (gnt[2'(i)]) order.push_back(i);
        if (order.size() > 1) check("rr_gap", 64'(gap), 64'd1);
        gap = 0;
      end else if (gnt == '0) begin
        gap++;
      end
      prev  = gnt;
      m_cyc = '1;
      if (mdl_owner >= 0) begin
        if (hold >= 1) m_cyc[2'(mdl_owner)] = 1'b0;
        hold++;
      end else begin
        hold = 0;
      end
      cycle("rr");
    end
    check("rr_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i % N));

    // Reset mid-transfer: master 2 owns the bus while the pointer is non-zero
    do_reset();
    set_master(1, 1'b0, 32'h8, 4'hF, '0);
    cycle("rst_m1");
    m_cyc[1] = 1'b0;
    cycle("rst_rel1");
    set_master(2, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5);
    cycle("rst_req2");
    check("rst_own2", 64'(gnt), 64'(4'b0100));
    #2 rst = 1'b0;
    mdl_owner = -1;
    mdl_ptr   = 0;
    #1;
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_gnt", 64'(gnt), 64'(4'b0000));
    compare_outputs("rst_mid");
    @(negedge clk);
    rst   = 1'b1;
    m_cyc = '1;
    m_stb = '1;
    cycle("rst_all");
    check("rst_ptr0", 64'(gnt), 64'(4'b0001));
    clear_inputs();
    cycle("rst_end");

    // Random phase
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[2'(i)]) begin
          if ($urandom_range(0, 4) == 0) m_cyc[2'(i)] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc[2'(i)] = 1'b1;
        end
        m_stb[2'(i)]          = 1'($urandom_range(0, 1));
        m_we[2'(i)]           = 1'($urandom_range(0, 1));
        m_adr[i * AW +: AW]   = $urandom;
        m_sel[i * SW +: SW]   = 4'($urandom_range(0, 15));
        m_dat_w[i * DW +: DW] = $urandom;
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 5) == 0);
      s_rty   = ($urandom_range(0, 5) == 0);
      s_dat_r = $urandom;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
